// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready stream FIFO with first-word-fall-through output.
// Storage is a circular buffer indexed by read/write pointers; occupancy is
// tracked by an explicit counter so that full and empty are unambiguous.
// The ready/valid outputs have no combinational path between the two sides.

module stream_fifo #(
    parameter int Width = 16,
    parameter int Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [Width-1:0]         s_data_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [Width-1:0]         m_data_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(Depth);
    localparam logic [CW-1:0] EMPTY_CNT = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic push_s;
    logic pop_s;

    // Handshake outputs: ready is also forced low while reset is held so no
    // word can be accepted on an edge that reset owns.
    always_comb begin
        s_ready_o = (count_q != FULL_CNT) && !rst_i;
        m_valid_o = (count_q != EMPTY_CNT);
        m_data_o  = mem_q[rd_ptr_q];
        count_o   = count_q;
        push_s    = s_valid_i && s_ready_o;
        pop_s     = m_valid_o && m_ready_i;
    end

    // Next-state for pointers and occupancy; pointers wrap naturally since
    // Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Next-state for storage: only the slot at the write pointer can change.
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = s_data_i;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
    end

    // Control state register; reset empties the FIFO immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= EMPTY_CNT;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage register; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed scenarios plus randomized stress for stream_fifo.
// A monitor samples the interface on the falling edge and compares against a
// queue-based reference model; the driver changes inputs shortly after the
// rising edge.

module tb_stream_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_i;
    logic             s_valid_i;
    logic             s_ready_o;
    logic [WIDTH-1:0] s_data_i;
    logic             m_valid_o;
    logic             m_ready_i;
    logic [WIDTH-1:0] m_data_o;
    logic [CW-1:0]    count_o;

    int n_pass  = 0;
    int n_total = 0;

    logic [WIDTH-1:0] model_q [$];

    stream_fifo #(
        .Width (WIDTH),
        .Depth (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .count_o   (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus; returns 2 time units after the sampling edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r);
        s_valid_i = v;
        s_data_i  = d;
        m_ready_i = r;
        @(posedge clk);
        #2;
    endtask

    // Monitor: model state before the edge predicts outputs and handshakes.
    always @(negedge clk) begin
        int  sz;
        bit  do_pop;
        bit  do_push;
        if (rst_i) begin
            chk("rst_count", 32'(count_o), 32'd0);
            chk("rst_m_valid", 32'(m_valid_o), 32'd0);
            chk("rst_s_ready", 32'(s_ready_o), 32'd0);
            model_q.delete();
        end else begin
            sz      = model_q.size();
            do_pop  = (sz != 0) && m_ready_i;
            do_push = s_valid_i && (sz != DEPTH);
            chk("count", 32'(count_o), 32'(sz));
            chk("m_valid", 32'(m_valid_o), 32'(sz != 0));
            chk("s_ready", 32'(s_ready_o), 32'(sz != DEPTH));
            chk("count_le_depth", 32'(count_o <= CW'(DEPTH)), 32'd1);
            if (do_pop) begin
                chk("pop_data", 32'(m_data_o), 32'(model_q[0]));
                void'(model_q.pop_front());
            end
            if (do_push) begin
                model_q.push_back(s_data_i);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Directed scenarios followed by randomized stress.
    initial begin
        logic [WIDTH-1:0] w;
        rst_i     = 1'b1;
        s_valid_i = 1'b0;
        s_data_i  = 16'h0000;
        m_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_count", 32'(count_o), 32'd0);
        chk("reset_s_ready", 32'(s_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        chk("post_reset_s_ready", 32'(s_ready_o), 32'd1);
        @(posedge clk);
        #2;

        // Basic latency.
        step(1'b1, 16'h1234, 1'b0);
        chk("lat_m_valid", 32'(m_valid_o), 32'd1);
        chk("lat_m_data", 32'(m_data_o), 32'h1234);
        chk("lat_count", 32'(count_o), 32'd1);
        step(1'b0, 16'h0000, 1'b1);
        chk("lat_drained", 32'(count_o), 32'd0);

        // Fill to full, drop an extra push, drain in order.
        for (int i = 1; i <= 4; i++) begin
            w = 16'hA000 + 16'(i);
            step(1'b1, w, 1'b0);
        end
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_s_ready", 32'(s_ready_o), 32'd0);
        step(1'b1, 16'hA005, 1'b0);
        chk("full_drop_count", 32'(count_o), 32'd4);
        chk("full_head", 32'(m_data_o), 32'hA001);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0000, 1'b1);
        end
        chk("drain_count", 32'(count_o), 32'd0);
        step(1'b0, 16'h0000, 1'b1);
        chk("empty_pop_ignored", 32'(count_o), 32'd0);

        // Simultaneous push/pop at steady occupancy 2, across wrap.
        step(1'b1, 16'hC000, 1'b0);
        step(1'b1, 16'hC001, 1'b0);
        for (int i = 2; i < 12; i++) begin
            w = 16'hC000 + 16'(i);
            step(1'b1, w, 1'b1);
            chk("pp_count", 32'(count_o), 32'd2);
            chk("pp_head", 32'(m_data_o), 32'(16'hC000 + 16'(i - 1)));
        end
        step(1'b0, 16'h0000, 1'b1);
        step(1'b0, 16'h0000, 1'b1);
        chk("pp_drained", 32'(count_o), 32'd0);

        // Backpressure hold at occupancy 3.
        step(1'b1, 16'hB001, 1'b0);
        step(1'b1, 16'hB002, 1'b0);
        step(1'b1, 16'hB003, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'h0000, 1'b0);
            chk("hold_data", 32'(m_data_o), 32'hB001);
            chk("hold_valid", 32'(m_valid_o), 32'd1);
            chk("hold_count", 32'(count_o), 32'd3);
        end

        // Asynchronous reset mid-cycle with occupancy 3.
        #1;
        rst_i = 1'b1;
        #1;
        chk("async_rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("async_rst_count", 32'(count_o), 32'd0);
        chk("async_rst_s_ready", 32'(s_ready_o), 32'd0);
        @(negedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        chk("rel_s_ready", 32'(s_ready_o), 32'd1);
        @(posedge clk);
        #2;
        step(1'b1, 16'h00FF, 1'b0);
        chk("after_rst_head", 32'(m_data_o), 32'h00FF);
        chk("after_rst_count", 32'(count_o), 32'd1);
        step(1'b0, 16'h0000, 1'b1);

        // Randomized stress with phase-varying bias.
        for (int i = 0; i < 10000; i++) begin
            int bias_v;
            int bias_r;
            bias_v = ((i / 500) % 3) + 1;
            bias_r = (((i / 700) + 1) % 3) + 1;
            step(($urandom_range(0, 3) < bias_v) ? 1'b1 : 1'b0,
                 16'($urandom),
                 ($urandom_range(0, 3) < bias_r) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b0, 16'h0000, 1'b1);
        end
        chk("final_empty", 32'(count_o), 32'd0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
